// File: rtl/ps2_dir_pkg.sv
// rtl/ps2_dir_pkg.sv - shared constants and types for the PS/2 direction decoder
// Purpose: one-hot direction encodings, scan-code constants, FSM state
//          enums and the opposite-direction helper.
// Ports:   none (package).
package ps2_dir_pkg;

  // One-hot direction commands driven to the move stages
  localparam logic [4:0] DIR_NONE  = 5'b10000;
  localparam logic [4:0] DIR_UP    = 5'b01000;
  localparam logic [4:0] DIR_DOWN  = 5'b00100;
  localparam logic [4:0] DIR_LEFT  = 5'b00010;
  localparam logic [4:0] DIR_RIGHT = 5'b00001;

  // Scan codes (set 2)
  localparam logic [7:0] SC_EXT   = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BRK   = 8'hF0;  // break (release) prefix
  localparam logic [7:0] SC_UP    = 8'h75;  // arrow up   (after E0)
  localparam logic [7:0] SC_DOWN  = 8'h72;  // arrow down (after E0)
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // arrow left (after E0)
  localparam logic [7:0] SC_RIGHT = 8'h74;  // arrow right(after E0)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    D_BASE,
    D_EXT,
    D_BRK,
    D_EXT_BRK
  } dec_state_t;

  // Opposite of a one-hot direction; NONE has no opposite and maps to an
  // all-zero pattern that can never equal a decoded command.
  function automatic logic [4:0] dir_opposite(input logic [4:0] d);
    logic [4:0] o;
    case (d)
      DIR_UP:    o = DIR_DOWN;
      DIR_DOWN:  o = DIR_UP;
      DIR_LEFT:  o = DIR_RIGHT;
      DIR_RIGHT: o = DIR_LEFT;
      default:   o = 5'b00000;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver with synchronizers, clock filter and timeout
// Purpose: conditions the raw PS/2 lines and assembles 11-bit frames
//          (start, 8 data LSB-first, odd parity, stop) into bytes.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   raw keyboard lines, asynchronous to clk
//   rx_byte[7:0]        last assembled byte, valid while byte_strobe is high
//   byte_strobe         one-cycle pulse per good byte
//   frame_err           one-cycle pulse on parity/stop error or timeout
module ps2_rx
  import ps2_dir_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronizers; idle PS/2 lines are high, so reset to 1
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sync_clk;
  logic                   sync_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];

  // Glitch filter: the filtered level follows sync_clk only after
  // FILTER_LEN consecutive samples disagree with it. Any agreeing sample
  // restarts the count.
  logic [FW-1:0] flt_cnt;
  logic          filt_clk;
  logic          fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt  <= '0;
      filt_clk <= 1'b1;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_clk == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt  <= '0;
        filt_clk <= sync_clk;
        fall     <= filt_clk;  // strobe only on a 1 -> 0 change
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  // Receiver FSM
  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          strobe_n;
  logic          err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RX_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      to_cnt      <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      par_bit     <= par_n;
      to_cnt      <= to_cnt_n;
      byte_strobe <= strobe_n;
      frame_err   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par_bit;
    strobe_n  = 1'b0;
    err_n     = 1'b0;

    if (state == RX_IDLE || fall) begin
      to_cnt_n = '0;
    end else begin
      to_cnt_n = to_cnt + TW'(1);
    end

    case (state)
      RX_IDLE: begin
        if (fall && !sync_data) begin
          state_n   = RX_DATA;
          bit_cnt_n = '0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_n   = {sync_data, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_n   = sync_data;
          state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          if (sync_data && (^{shift, par_bit})) begin
            strobe_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase

    // A stalled frame is abandoned so the next start bit is not misread
    if (state != RX_IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n  = RX_IDLE;
      err_n    = 1'b1;
      to_cnt_n = '0;
    end
  end

  assign rx_byte = shift;

endmodule

// File: rtl/ps2_dir_decoder.sv
// rtl/ps2_dir_decoder.sv - PS/2 keyboard to two-player one-hot direction decoder
// Purpose: player 1 steers with E0-extended arrow keys, player 2 with
//          W/A/S/D. Optional macro REVERSE_LOCK_EN discards a command that
//          is exactly opposite to the player's current direction.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   raw keyboard lines, asynchronous to clk
//   dir1[4:0]           player-1 direction, one-hot
//   dir2[4:0]           player-2 direction, one-hot
//   dir_valid           one-cycle pulse when dir1 or dir2 changes
//   frame_err           one-cycle pulse on a bad or timed-out frame
module ps2_dir_decoder
  import ps2_dir_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] dir1,
  output logic [4:0] dir2,
  output logic       dir_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_strobe;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .frame_err  (frame_err)
  );

  dec_state_t d_state, d_next;
  logic [4:0] dir1_n, dir2_n;
  logic       dir_valid_n;
  logic       cmd1_hit, cmd2_hit;
  logic [4:0] cmd1, cmd2;
  logic       block1, block2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state   <= D_BASE;
      dir1      <= DIR_NONE;
      dir2      <= DIR_NONE;
      dir_valid <= 1'b0;
    end else begin
      d_state   <= d_next;
      dir1      <= dir1_n;
      dir2      <= dir2_n;
      dir_valid <= dir_valid_n;
    end
  end

  always_comb begin
    d_next   = d_state;
    cmd1_hit = 1'b0;
    cmd2_hit = 1'b0;
    cmd1     = DIR_NONE;
    cmd2     = DIR_NONE;

    if (byte_strobe) begin
      case (d_state)
        D_BASE: begin
          case (rx_byte)
            SC_EXT: d_next = D_EXT;
            SC_BRK: d_next = D_BRK;
            SC_W:   begin cmd2_hit = 1'b1; cmd2 = DIR_UP;    end
            SC_A:   begin cmd2_hit = 1'b1; cmd2 = DIR_LEFT;  end
            SC_S:   begin cmd2_hit = 1'b1; cmd2 = DIR_DOWN;  end
            SC_D:   begin cmd2_hit = 1'b1; cmd2 = DIR_RIGHT; end
            default: d_next = D_BASE;
          endcase
        end
        D_EXT: begin
          d_next = D_BASE;
          case (rx_byte)
            SC_EXT:   d_next = D_EXT;  // repeated prefix
            SC_BRK:   d_next = D_EXT_BRK;
            SC_UP:    begin cmd1_hit = 1'b1; cmd1 = DIR_UP;    end
            SC_LEFT:  begin cmd1_hit = 1'b1; cmd1 = DIR_LEFT;  end
            SC_DOWN:  begin cmd1_hit = 1'b1; cmd1 = DIR_DOWN;  end
            SC_RIGHT: begin cmd1_hit = 1'b1; cmd1 = DIR_RIGHT; end
            default:  d_next = D_BASE;
          endcase
        end
        // Released key code is swallowed; snakes keep moving on release
        D_BRK:     d_next = D_BASE;
        D_EXT_BRK: d_next = D_BASE;
        default:   d_next = D_BASE;
      endcase
    end

`ifdef REVERSE_LOCK_EN
    block1 = (cmd1 == dir_opposite(dir1));
    block2 = (cmd2 == dir_opposite(dir2));
`else
    block1 = 1'b0;
    block2 = 1'b0;
`endif

    dir1_n = (cmd1_hit && !block1) ? cmd1 : dir1;
    dir2_n = (cmd2_hit && !block2) ? cmd2 : dir2;

    // Typematic repeats re-apply the same value and so raise no pulse
    dir_valid_n = (dir1_n != dir1) || (dir2_n != dir2);
  end

endmodule
